// File: rtl/bcd_to_binary.sv
// Serial packed-BCD to binary converter: one decimal digit per clock, MSD first.
// Requests containing a non-decimal nibble are rejected in one cycle with error set.
module bcd_to_binary #(
  parameter int DIGITS = 5,
  parameter int BIN_W  = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   inBCD,
  output logic [BIN_W-1:0]      outNum,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int SR_W   = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WIDE_W = BIN_W + 4;

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t             state_reg;
  logic [SR_W-1:0]    sr_reg;
  logic [BIN_W-1:0]   acc_reg;
  logic [IDX_W-1:0]   idx_reg;

  // Per-nibble legality of the incoming request.
  logic [DIGITS-1:0]  nib_bad;
  logic               any_bad;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_nib_chk
      assign nib_bad[gi] = (inBCD[4*gi +: 4] > 4'd9);
    end
  endgenerate

  assign any_bad = |nib_bad;

  // The digit being folded in is always the top nibble of the shift register.
  logic [3:0]         cur_digit;
  logic [WIDE_W-1:0]  acc_wide;
  logic [WIDE_W-1:0]  acc_sum;
  logic [BIN_W-1:0]   acc_next;
  logic               unused_hi;

  assign cur_digit = sr_reg[SR_W-1 -: 4];
  assign acc_wide  = {4'b0000, acc_reg};
  // acc*10 as acc*8 + acc*2, done wide enough that the intermediate never wraps.
  assign acc_sum   = (acc_wide << 3) + (acc_wide << 1) + WIDE_W'(cur_digit);
  assign acc_next  = acc_sum[BIN_W-1:0];
  assign unused_hi = ^acc_sum[WIDE_W-1:BIN_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sr_reg    <= '0;
      acc_reg   <= '0;
      idx_reg   <= '0;
      outNum    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start) begin
            sr_reg <= inBCD;
            if (any_bad) begin
              outNum <= '0;
              error  <= 1'b1;
              done   <= 1'b1;
            end else begin
              acc_reg   <= '0;
              idx_reg   <= IDX_W'(DIGITS - 1);
              busy      <= 1'b1;
              error     <= 1'b0;
              state_reg <= CONV;
            end
          end
        end
        CONV: begin
          // start and inBCD are deliberately ignored here; the shift register owns the operand.
          sr_reg <= sr_reg << 4;
          if (idx_reg == '0) begin
            acc_reg   <= acc_next;
            outNum    <= acc_next;
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            acc_reg <= acc_next;
            idx_reg <= idx_reg - 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// Directed bench for bcd_to_binary: a cycle model built from decimal arithmetic and a
// request countdown is compared every cycle, plus hand-computed literal expectations.
module tb_bcd_to_binary;

  localparam int DIGITS = 5;
  localparam int BIN_W  = 17;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [19:0]       inBCD = '0;
  logic [BIN_W-1:0]  outNum;
  logic              busy;
  logic              done;
  logic              error;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  bit checking = 1'b0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inBCD  (inBCD),
    .outNum (outNum),
    .busy   (busy),
    .done   (done),
    .error  (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: sum of digit * 10^position.
  function automatic int bcd_val(input logic [19:0] v);
    int p = 1;
    int r = 0;
    for (int i = 0; i < DIGITS; i++) begin
      r += int'(v[4*i +: 4]) * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic bit bcd_bad(input logic [19:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural model: a pending request matures DIGITS edges after acceptance.
  int m_out = 0, m_busy = 0, m_done = 0, m_err = 0, m_cnt = 0, m_pend = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_out <= 0; m_busy <= 0; m_done <= 0; m_err <= 0; m_cnt <= 0; m_pend <= 0;
    end else begin
      m_done <= 0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_out  <= m_pend;
          m_done <= 1;
          m_busy <= 0;
        end
      end else if (start) begin
        if (bcd_bad(inBCD)) begin
          m_out  <= 0;
          m_err  <= 1;
          m_done <= 1;
        end else begin
          m_pend <= bcd_val(inBCD);
          m_cnt  <= DIGITS;
          m_busy <= 1;
          m_err  <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (checking) begin
      check("cyc_outNum", 32'(outNum), 32'(m_out));
      check("cyc_busy",   32'(busy),   32'(m_busy));
      check("cyc_done",   32'(done),   32'(m_done));
      check("cyc_error",  32'(error),  32'(m_err));
    end
  end

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input logic [19:0] v);
    $display("[TB] request inBCD=%05h", v);
    start = 1'b1;
    inBCD = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat counts edges after the start-sampling edge until done is visible.
  task automatic wait_done(input string name, input int exp_val, input int exp_lat, input int exp_err);
    int lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    $display("[TB] %s: done after %0d edges, outNum=%0d error=%0b", name, lat, outNum, error);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_outNum"}, 32'(outNum), 32'(exp_val));
    check({name, "_error"}, 32'(error), 32'(exp_err));
  endtask

  initial begin
    int d0;
    check("model_43456", 32'(bcd_val(20'h43456)), 32'd43456);
    check("model_99999", 32'(bcd_val(20'h99999)), 32'd99999);
    check("model_bad",   32'(bcd_bad(20'h4A456)), 32'd1);

    repeat (3) @(negedge clk);
    checking = 1'b1;
    check("reset_outNum", 32'(outNum), 32'd0);
    check("reset_busy",   32'(busy),   32'd0);
    check("reset_done",   32'(done),   32'd0);
    check("reset_error",  32'(error),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(20'h43456);
    check("43456_busy", 32'(busy), 32'd1);
    wait_done("43456", 43456, 5, 0);
    @(negedge clk);
    check("43456_done_clears", 32'(done), 32'd0);

    issue(20'h99999);
    wait_done("99999", 99999, 5, 0);
    issue(20'h00000);
    wait_done("zero", 0, 5, 0);
    repeat (2) @(negedge clk);

    issue(20'h4A456);
    check("bad_busy", 32'(busy), 32'd0);
    wait_done("bad", 0, 0, 1);
    @(negedge clk);
    issue(20'h00999);
    wait_done("999", 999, 5, 0);
    repeat (2) @(negedge clk);

    d0 = done_cnt;
    issue(20'h12345);
    @(negedge clk);
    issue(20'h54321);
    wait_done("ignore2nd", 12345, 3, 0);
    repeat (10) @(negedge clk);
    check("ignore2nd_pulses", 32'(done_cnt - d0), 32'd1);

    d0 = done_cnt;
    issue(20'h43725);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outNum", 32'(outNum), 32'd0);
    check("abort_busy",   32'(busy),   32'd0);
    check("abort_done",   32'(done),   32'd0);
    check("abort_error",  32'(error),  32'd0);
    repeat (8) @(negedge clk);
    check("abort_pulses", 32'(done_cnt - d0), 32'd0);
    issue(20'h43725);
    wait_done("restart", 43725, 5, 0);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
